// File: rtl/jt1943_dwnld_sched.sv
// Download write scheduler: buffers mapped ROM writes in a small FIFO, issues
// them to the SDRAM write port, and sequences the game reset at download end.
//
// SDRAM handshake: sdram_req is a registered request that stays high, with
// sdram_addr/sdram_din/sdram_mask held at the FIFO head, until the cycle
// sdram_ack is sampled high. That cycle pops the head. sdram_req is low for
// the following cycle and re-rises only if entries remain. An ack seen while
// sdram_req is low is ignored.
module jt1943_dwnld_sched #(
    parameter int AW   = 2,
    parameter int HOLD = 16
) (
    input  logic        clk_rom,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        prog_we,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    output logic        ioctl_wait,
    output logic        sdram_req,
    output logic [21:0] sdram_addr,
    output logic [15:0] sdram_din,
    output logic [1:0]  sdram_mask,
    input  logic        sdram_ack,
    output logic        game_rst,
    output logic        dwnld_done,
    output logic [21:0] wr_count,
    output logic        overflow
);

    localparam int            DEPTH   = 1 << AW;
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [AW:0]   WAIT_V  = (AW+1)'(DEPTH - 1);
    localparam logic [15:0]   HOLD_V  = 16'(HOLD - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DRAIN,
        S_HOLD,
        S_DONE
    } state_t;

    state_t        state, state_nx;
    logic          dl_q;
    logic          rise;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   occ, occ_nx;
    logic          active, full, push, pop, drop;
    logic          req_nx;
    logic          enter_load;
    logic [15:0]   hold_cnt;

    logic [21:0]   mem_addr [DEPTH];
    logic [7:0]    mem_data [DEPTH];
    logic [1:0]    mem_mask [DEPTH];

    assign rise       = downloading & ~dl_q;
    assign active     = (state == S_LOAD) || (state == S_DRAIN);
    assign full       = (occ == DEPTH_V);
    assign pop        = sdram_req & sdram_ack;
    // A full FIFO still takes a write in the same cycle the head leaves.
    assign push       = active & prog_we & (~full | pop);
    assign drop       = active & prog_we & full & ~pop;
    assign enter_load = (state_nx == S_LOAD) && (state != S_LOAD);

    assign sdram_addr = mem_addr[rd_ptr];
    assign sdram_din  = {mem_data[rd_ptr], mem_data[rd_ptr]};
    assign sdram_mask = mem_mask[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        occ_nx = occ;
        if (push && !pop) begin
            occ_nx = occ + 1'b1;
        end else if (pop && !push) begin
            occ_nx = occ - 1'b1;
        end
    end

    // Request for next cycle: drop on ack, hold while pending, else raise on data.
    always_comb begin
        req_nx = 1'b0;
        if (pop) begin
            req_nx = 1'b0;
        end else if (sdram_req) begin
            req_nx = 1'b1;
        end else if (active && occ != '0) begin
            req_nx = 1'b1;
        end
    end

    // Next-state logic; a downloading rising edge outranks drain/hold completion.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (rise) state_nx = S_LOAD;
            S_LOAD:  if (!downloading) state_nx = S_DRAIN;
            S_DRAIN: begin
                if (rise) begin
                    state_nx = S_LOAD;
                end else if (occ_nx == '0 && !req_nx) begin
                    state_nx = S_HOLD;
                end
            end
            S_HOLD: begin
                if (rise) begin
                    state_nx = S_LOAD;
                end else if (hold_cnt == HOLD_V) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE:  if (rise) state_nx = S_LOAD;
            default: state_nx = S_IDLE;
        endcase
    end

    // State register, edge history, hold timer and registered status outputs.
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            dl_q       <= 1'b0;
            hold_cnt   <= '0;
            game_rst   <= 1'b1;
            dwnld_done <= 1'b0;
        end else begin
            state      <= state_nx;
            dl_q       <= downloading;
            game_rst   <= (state_nx != S_DONE);
            dwnld_done <= (state_nx == S_DONE);
            if (state == S_DRAIN && state_nx == S_HOLD) begin
                hold_cnt <= '0;
            end else if (state == S_HOLD) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end

    // FIFO pointers, occupancy, stall flag and SDRAM request.
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occ        <= '0;
            ioctl_wait <= 1'b0;
            sdram_req  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            occ        <= occ_nx;
            ioctl_wait <= (occ_nx >= WAIT_V);
            sdram_req  <= req_nx;
        end
    end

    // Per-download statistics, cleared whenever a new download begins.
    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            overflow <= 1'b0;
        end else if (enter_load) begin
            wr_count <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)  wr_count <= wr_count + 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Entry storage; contents need no reset since occupancy gates their use.
    always_ff @(posedge clk_rom) begin
        if (push) begin
            mem_addr[wr_ptr] <= prog_addr;
            mem_data[wr_ptr] <= prog_data;
            mem_mask[wr_ptr] <= prog_mask;
        end
    end

endmodule

// File: tb/tb_jt1943_dwnld_sched.sv
// Bench for jt1943_dwnld_sched: directed download scenarios, a queue-based
// reference model checked every cycle, and literal spot checks.
module tb_jt1943_dwnld_sched;

    localparam int DEPTH = 4;
    localparam int HOLD  = 16;

    logic        clk_rom = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic        prog_we;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        ioctl_wait;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic [15:0] sdram_din;
    logic [1:0]  sdram_mask;
    logic        sdram_ack;
    logic        game_rst;
    logic        dwnld_done;
    logic [21:0] wr_count;
    logic        overflow;

    int compared = 0;
    int failed   = 0;
    bit chk_en   = 0;

    jt1943_dwnld_sched #(.AW(2), .HOLD(HOLD)) dut (
        .clk_rom     (clk_rom),
        .rst_n       (rst_n),
        .downloading (downloading),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .prog_mask   (prog_mask),
        .ioctl_wait  (ioctl_wait),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_din   (sdram_din),
        .sdram_mask  (sdram_mask),
        .sdram_ack   (sdram_ack),
        .game_rst    (game_rst),
        .dwnld_done  (dwnld_done),
        .wr_count    (wr_count),
        .overflow    (overflow)
    );

    // Clock
    always #5 clk_rom = ~clk_rom;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [21:0] a;
        logic [7:0]  d;
        logic [1:0]  m;
    } ent_t;

    typedef enum {P_IDLE, P_LOAD, P_DRAIN, P_HOLD, P_DONE} ph_t;

    ent_t        mq[$];
    ent_t        m_ent;
    ph_t         ph, nph;
    bit          m_dl, m_req, m_wait, m_ovf, m_grst, m_done;
    bit          m_rise, m_pop, m_active, m_take, m_lost, m_reload, m_req_new;
    logic [21:0] m_wr;
    int          m_hold, m_n;

    always @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            ph     = P_IDLE;
            m_dl   = 0;
            m_req  = 0;
            m_wait = 0;
            m_ovf  = 0;
            m_grst = 1;
            m_done = 0;
            m_wr   = '0;
            m_hold = 0;
        end else begin
            m_n      = mq.size();
            m_rise   = downloading && !m_dl;
            m_pop    = m_req && sdram_ack;
            m_active = (ph == P_LOAD) || (ph == P_DRAIN);
            m_take   = m_active && prog_we && ((m_n < DEPTH) || m_pop);
            m_lost   = m_active && prog_we && (m_n == DEPTH) && !m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_take) begin
                m_ent = {prog_addr, prog_data, prog_mask};
                mq.push_back(m_ent);
            end
            m_req_new = m_pop ? 1'b0 : (m_req ? 1'b1 : (m_active && m_n > 0));
            nph = ph;
            if (ph != P_LOAD && ph != P_IDLE && m_rise) nph = P_LOAD;
            else if (ph == P_IDLE && m_rise) nph = P_LOAD;
            else if (ph == P_LOAD && !downloading) nph = P_DRAIN;
            else if (ph == P_DRAIN && mq.size() == 0 && !m_req_new) nph = P_HOLD;
            else if (ph == P_HOLD && m_hold == HOLD - 1) nph = P_DONE;
            if (nph == P_HOLD && ph != P_HOLD) m_hold = 0;
            else if (ph == P_HOLD) m_hold++;
            m_reload = (nph == P_LOAD) && (ph != P_LOAD);
            if (m_reload) begin
                m_wr  = '0;
                m_ovf = 0;
            end else begin
                if (m_pop)  m_wr = m_wr + 22'd1;
                if (m_lost) m_ovf = 1;
            end
            m_wait = (mq.size() >= DEPTH - 1);
            m_req  = m_req_new;
            ph     = nph;
            m_grst = (ph != P_DONE);
            m_done = (ph == P_DONE);
            m_dl   = downloading;
        end
    end

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk_rom) begin
        if (chk_en) begin
            chk("m_ioctl_wait", ioctl_wait, m_wait);
            chk("m_sdram_req", sdram_req, m_req);
            chk("m_game_rst", game_rst, m_grst);
            chk("m_dwnld_done", dwnld_done, m_done);
            chk("m_wr_count", wr_count, m_wr);
            chk("m_overflow", overflow, m_ovf);
            if (m_req && mq.size() > 0) begin
                chk("m_sdram_addr", sdram_addr, mq[0].a);
                chk("m_sdram_din", sdram_din, {mq[0].d, mq[0].d});
                chk("m_sdram_mask", sdram_mask, mq[0].m);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_rom);
            #1;
        end
    endtask

    task automatic push(input logic [21:0] a, input logic [7:0] d, input logic [1:0] m);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        prog_mask = m;
        step(1);
        prog_we   = 1'b0;
    endtask

    task automatic start_dl();
        downloading = 1'b1;
        step(1);
    endtask

    task automatic reset_dut();
        rst_n       = 1'b0;
        downloading = 1'b0;
        prog_we     = 1'b0;
        sdram_ack   = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
    endtask

    // Wait (bounded) for a request, check the head entry, then acknowledge it.
    task automatic do_ack(input string nm, input logic [21:0] ea, input logic [7:0] ed,
                          input logic [1:0] em);
        int t = 0;
        while (sdram_req !== 1'b1 && t < 20) begin
            step(1);
            t++;
        end
        if (sdram_req !== 1'b1) begin
            compared++;
            failed++;
            $display("FAIL %s_timeout: got req=%b expected req=1 within 20 cycles", nm, sdram_req);
        end else begin
            chk({nm, "_addr"}, sdram_addr, ea);
            chk({nm, "_din"}, sdram_din, {ed, ed});
            chk({nm, "_mask"}, sdram_mask, em);
            sdram_ack = 1'b1;
            step(1);
            sdram_ack = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        downloading = 0;
        prog_we     = 0;
        prog_addr   = '0;
        prog_data   = '0;
        prog_mask   = '0;
        sdram_ack   = 0;
        rst_n       = 1;
        #1 rst_n = 0;
        chk_en = 1;

        // Reset held with strobes toggling
        for (int i = 0; i < 4; i++) begin
            prog_we   = i[0];
            sdram_ack = ~i[0];
            step(1);
        end
        prog_we   = 0;
        sdram_ack = 0;
        chk("rst_game_rst", game_rst, 1);
        chk("rst_dwnld_done", dwnld_done, 0);
        chk("rst_sdram_req", sdram_req, 0);
        chk("rst_ioctl_wait", ioctl_wait, 0);
        chk("rst_wr_count", wr_count, 0);
        chk("rst_overflow", overflow, 0);
        rst_n = 1;
        step(2);
        chk("idle_game_rst", game_rst, 1);
        chk("idle_req", sdram_req, 0);

        // Single write
        start_dl();
        push(22'h00123, 8'hA5, 2'b10);
        chk("sw_req_push_cycle", sdram_req, 0);
        step(1);
        chk("sw_req_rise", sdram_req, 1);
        chk("sw_din", sdram_din, 16'hA5A5);
        chk("sw_mask", sdram_mask, 2'b10);
        chk("sw_addr", sdram_addr, 22'h00123);
        step(1);
        chk("sw_req_held", sdram_req, 1);
        sdram_ack = 1;
        step(1);
        sdram_ack = 0;
        chk("sw_req_drop", sdram_req, 0);
        chk("sw_wr_count", wr_count, 1);
        step(1);
        chk("sw_req_idle", sdram_req, 0);

        // Back-pressure with ack withheld
        reset_dut();
        start_dl();
        for (int i = 0; i < 5; i++) begin
            push(22'h000100 + 22'(i), 8'hB0 + 8'(i), 2'(i));
            if (i == 1) chk("bp_wait_after2", ioctl_wait, 0);
            if (i == 2) chk("bp_wait_after3", ioctl_wait, 1);
            if (i == 3) chk("bp_ovf_after4", overflow, 0);
            if (i == 4) chk("bp_ovf_after5", overflow, 1);
        end
        for (int k = 0; k < 4; k++) begin
            do_ack("bp_ack", 22'h000100 + 22'(k), 8'hB0 + 8'(k), 2'(k));
        end
        chk("bp_wr_count", wr_count, 4);
        step(1);
        chk("bp_wait_empty", ioctl_wait, 0);
        chk("bp_req_empty", sdram_req, 0);

        // Simultaneous push and ack with the FIFO full
        reset_dut();
        start_dl();
        for (int i = 0; i < 4; i++) push(22'h002000 + 22'(i), 8'hC0 + 8'(i), 2'b01);
        chk("sim_wait_full", ioctl_wait, 1);
        chk("sim_req_pending", sdram_req, 1);
        prog_we   = 1;
        prog_addr = 22'h002004;
        prog_data = 8'hC4;
        prog_mask = 2'b11;
        sdram_ack = 1;
        step(1);
        prog_we   = 0;
        sdram_ack = 0;
        chk("sim_ovf", overflow, 0);
        chk("sim_wait_still_full", ioctl_wait, 1);
        for (int k = 1; k < 4; k++) do_ack("sim_ack", 22'h002000 + 22'(k), 8'hC0 + 8'(k), 2'b01);
        do_ack("sim_ack_last", 22'h002004, 8'hC4, 2'b11);
        chk("sim_wr_count", wr_count, 5);

        // End of download with two entries pending
        push(22'h3FFFFE, 8'h5A, 2'b00);
        push(22'h3FFFFF, 8'h3C, 2'b01);
        downloading = 0;
        step(1);
        do_ack("end_ack0", 22'h3FFFFE, 8'h5A, 2'b00);
        do_ack("end_ack1", 22'h3FFFFF, 8'h3C, 2'b01);
        chk("end_wr_count", wr_count, 7);
        cnt = 0;
        while (game_rst === 1'b1 && cnt < 100) begin
            cnt++;
            step(1);
        end
        chk("end_hold_cycles", cnt, HOLD);
        chk("end_game_rst", game_rst, 0);
        chk("end_done", dwnld_done, 1);
        step(2);
        chk("done_stays", dwnld_done, 1);

        // Restart from DONE
        start_dl();
        chk("rd_game_rst", game_rst, 1);
        chk("rd_done", dwnld_done, 0);
        chk("rd_wr_count", wr_count, 0);
        chk("rd_req", sdram_req, 0);

        // Restart from HOLD after an overflowing download
        for (int i = 0; i < 5; i++) push(22'h010000 + 22'(i), 8'hE0 + 8'(i), 2'b10);
        chk("rh_ovf_set", overflow, 1);
        downloading = 0;
        for (int k = 0; k < 4; k++) do_ack("rh_ack", 22'h010000 + 22'(k), 8'hE0 + 8'(k), 2'b10);
        step(3);
        chk("rh_in_hold_rst", game_rst, 1);
        chk("rh_wr_before", wr_count, 4);
        start_dl();
        chk("rh_wr_count", wr_count, 0);
        chk("rh_ovf", overflow, 0);
        chk("rh_game_rst", game_rst, 1);
        chk("rh_done", dwnld_done, 0);
        chk("rh_req", sdram_req, 0);
        chk("rh_wait", ioctl_wait, 0);
        push(22'h000042, 8'h77, 2'b00);
        do_ack("rh_after", 22'h000042, 8'h77, 2'b00);
        downloading = 0;
        step(HOLD + 8);
        chk("final_done", dwnld_done, 1);
        chk("final_wr_count", wr_count, 1);

        step(1);
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule

// File: doc/jt1943_dwnld_sched.md
Name: jt1943_dwnld_sched

Overview:
- Scheduler between the ROM-download address mapper and the SDRAM write port.
- Buffers mapped programming writes (address, data, mask, write-enable) in a small FIFO and issues them to SDRAM with a req/ack handshake.
- Back-pressures the download source through ioctl_wait.
- Sequences the end of the download: drains the FIFO, holds the game in reset for a fixed time, then releases it.

Parameters:
- AW, 2: log2 of FIFO depth; depth DEPTH = 2**AW entries.
- HOLD, 16: number of clk_rom cycles game_rst stays high after the drain completes; legal range 1..65535.

Ports:
- clk_rom  in  1  Single clock for the whole block.
- rst_n  in  1  Asynchronous, active-low reset.
- downloading  in  1  High while a ROM download is in progress.
- prog_we  in  1  One-cycle write strobe from the mapper.
- prog_addr  in  22  Word address.
- prog_data  in  8  Byte data.
- prog_mask  in  2  Byte-lane mask, active low.
- ioctl_wait  out  1  Stall request to the download source.
- sdram_req  out  1  Write request, held high until acknowledged.
- sdram_addr  out  22  Head-entry address.
- sdram_din  out  16  Head-entry data, {prog_data, prog_data}.
- sdram_mask  out  2  Head-entry mask.
- sdram_ack  in  1  One-cycle acknowledge from the SDRAM controller.
- game_rst  out  1  Active-high game reset.
- dwnld_done  out  1  High once the game is released.
- wr_count  out  22  Entries written to SDRAM in the current download.
- overflow  out  1  Sticky flag: a write arrived while the FIFO was full.

Behaviour:
- Asynchronous reset (rst_n low) sets all outputs and state:
  - game_rst=1; dwnld_done=0; sdram_req=0; ioctl_wait=0; wr_count=0; overflow=0.
  - FIFO pointers and occupancy = 0; state = IDLE; downloading history register = 0.
  - Reset mid-transfer abandons FIFO contents and any outstanding request.
- FIFO:
  - Push when prog_we=1 and occupancy<DEPTH.
  - prog_we with occupancy==DEPTH drops the entry and sets overflow.
  - Pop on sdram_ack while sdram_req=1. An ack while sdram_req=0 is ignored.
  - Simultaneous push and pop in one cycle leaves occupancy unchanged; this is legal even when full, and then no overflow occurs.
  - Pointers wrap modulo DEPTH.
- ioctl_wait is registered: high when next-cycle occupancy >= DEPTH-1, otherwise low.
- SDRAM handshake:
  - sdram_req is registered. It rises the cycle after the FIFO is non-empty, in states LOAD or DRAIN.
  - sdram_addr, sdram_din and sdram_mask always show the head entry and stay stable while sdram_req=1.
  - On ack, sdram_req drops the next cycle, giving exactly one idle cycle between transfers, then re-rises if entries remain.
  - wr_count increments by 1 per accepted ack and wraps at 2**22.
- Edge detect: a rising edge is downloading=1 while the registered previous value is 0.
- State machine:
  - IDLE:
    - game_rst=1, dwnld_done=0.
    - prog_we is ignored.
    - A rising edge moves to LOAD.
  - LOAD:
    - On entry, wr_count=0 and overflow=0.
    - Accept pushes and issue requests.
    - downloading=0 moves to DRAIN.
  - DRAIN:
    - Pushes are still accepted; requests continue.
    - When the FIFO is empty and sdram_req=0, clear the hold counter and move to HOLD.
    - A rising edge returns to LOAD without flushing the FIFO.
  - HOLD:
    - game_rst=1; the counter increments each cycle.
    - When counter==HOLD-1, move to DONE.
    - A rising edge moves to LOAD.
  - DONE:
    - game_rst=0, dwnld_done=1, both registered, so they change on the DONE entry edge.
    - A rising edge moves to LOAD. game_rst=1 and dwnld_done=0 take effect on that same LOAD entry edge.
- game_rst is 1 in every state except DONE.
- Priority when events coincide: reset > downloading edge > drain/hold completion.

Test Plan:
- Reset: hold rst_n=0 with prog_we and sdram_ack toggling -> all outputs at reset values; release -> IDLE, game_rst=1.
- Single write: rising edge of downloading, then prog_we with addr=22'h00123, data=8'hA5, mask=2'b10 -> sdram_req rises 1 cycle after the push with sdram_din=16'hA5A5 and sdram_mask=2'b10; ack -> req low the next cycle, wr_count=1.
- Back-pressure (AW=2, ack withheld):
  - 3 pushes -> ioctl_wait=1 after the 3rd.
  - 4th push accepted, 5th dropped -> overflow=1.
  - Then 4 acks -> 4 distinct entries in push order, wr_count=4.
- Simultaneous push and ack with FIFO full -> occupancy stays 4, overflow stays 0, order preserved.
- End sequence (HOLD=16): downloading falls with 2 entries pending -> both drained, then game_rst high for exactly 16 cycles after req drops, then game_rst=0 and dwnld_done=1.
- Restart in HOLD and in DONE: a downloading rising edge -> LOAD, wr_count=0, overflow=0, game_rst=1, dwnld_done=0; the FIFO is not disturbed.
